// File: rtl/disp_axil_regbank_if.sv
// rtl/disp_axil_regbank_if.sv - AXI4-Lite bus bundle for the display register bank
//
// Purpose: groups the AXI4-Lite write-address, write-data, write-response,
//          read-address and read-data channels into one bundle.
// Parameters: DATA_WIDTH (32 or 64), ADDR_WIDTH (byte address width).
// Modports:
//   master : drives AW*/W*/AR* payload and valids, BREADY, RREADY
//   slave  : drives AWREADY, WREADY, ARREADY, B*/R* payload and valids
interface disp_axil_regbank_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) ();
    logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic                    S_AXI_AWVALID;
    logic                    S_AXI_AWREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                    S_AXI_WVALID;
    logic                    S_AXI_WREADY;
    logic [1:0]              S_AXI_BRESP;
    logic                    S_AXI_BVALID;
    logic                    S_AXI_BREADY;
    logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic                    S_AXI_ARVALID;
    logic                    S_AXI_ARREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]              S_AXI_RRESP;
    logic                    S_AXI_RVALID;
    logic                    S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/disp_axil_regbank.sv
// rtl/disp_axil_regbank.sv - parametrised AXI4-Lite register bank for the display pipeline
//
// Purpose: NUM_REGS read/write control registers with byte strobes, NUM_STATUS
//          read-only status registers fed by hardware, SLVERR on writes to RO
//          registers and DECERR on unmapped indices.
// Optional feature macro: DISP_REGBANK_IRQ_EN adds IRQ_STAT (sticky, W1C) and
//          IRQ_EN registers right after the status block and drives irq.
//          Without it those two indices decode as unmapped and irq is 0.
// Ports:
//   ACLK       in   clock
//   ARESET     in   synchronous reset, active-high
//   s_axi      slave modport of disp_axil_regbank_if (AW/W/B/AR/R channels)
//   ctrl_out   out  RW registers, reg k at [k*DATA_WIDTH +: DATA_WIDTH]
//   status_in  in   RO register values, same packing, sampled at AR handshake
//   irq_src    in   level interrupt sources
//   irq        out  registered interrupt request
module disp_axil_regbank #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REGS   = 8,
    parameter int NUM_STATUS = 2,
    parameter int IRQ_WIDTH  = 4
) (
    input  logic                             ACLK,
    input  logic                             ARESET,
    disp_axil_regbank_if.slave               s_axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0]   ctrl_out,
    input  logic [NUM_STATUS*DATA_WIDTH-1:0] status_in,
    input  logic [IRQ_WIDTH-1:0]             irq_src,
    output logic                             irq
);
    localparam int STRB_W       = DATA_WIDTH / 8;
    localparam int ADDR_LSB     = $clog2(STRB_W);
    localparam int IDX_W        = ADDR_WIDTH - ADDR_LSB;
    localparam int IRQ_STAT_IDX = NUM_REGS + NUM_STATUS;
    localparam int IRQ_EN_IDX   = NUM_REGS + NUM_STATUS + 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // write channel holds
    logic                  r_aw_held;
    logic [IDX_W-1:0]      r_aw_idx;
    logic                  r_w_held;
    logic [DATA_WIDTH-1:0] r_w_data;
    logic [STRB_W-1:0]     r_w_strb;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;

    // read channel
    logic                  r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;

    logic [DATA_WIDTH-1:0] r_ctrl [NUM_REGS];

    logic                  w_awready;
    logic                  w_wready;
    logic                  w_arready;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_commit;
    logic [DATA_WIDTH-1:0] w_wmask;
    int                    w_aw_idx;
    int                    w_ar_idx;
    logic [1:0]            w_wr_resp;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic [1:0]            w_rd_resp;

    // Readies are forced low while reset is asserted so the bus sees a quiet slave.
    assign w_awready = !ARESET && !r_aw_held && !r_bvalid;
    assign w_wready  = !ARESET && !r_w_held  && !r_bvalid;
    assign w_arready = !ARESET && !r_rvalid;

    assign w_aw_hs = s_axi.S_AXI_AWVALID && w_awready;
    assign w_w_hs  = s_axi.S_AXI_WVALID  && w_wready;
    assign w_ar_hs = s_axi.S_AXI_ARVALID && w_arready;

    // Both halves held implies BVALID is low: readies stay off until the commit.
    assign w_commit = r_aw_held && r_w_held;

    assign w_aw_idx = int'(r_aw_idx);
    assign w_ar_idx = int'(s_axi.S_AXI_ARADDR[ADDR_WIDTH-1:ADDR_LSB]);

    assign s_axi.S_AXI_AWREADY = w_awready;
    assign s_axi.S_AXI_WREADY  = w_wready;
    assign s_axi.S_AXI_ARREADY = w_arready;
    assign s_axi.S_AXI_BVALID  = r_bvalid;
    assign s_axi.S_AXI_BRESP   = r_bresp;
    assign s_axi.S_AXI_RVALID  = r_rvalid;
    assign s_axi.S_AXI_RDATA   = r_rdata;
    assign s_axi.S_AXI_RRESP   = r_rresp;

    // Byte-offset address bits carry no information for register decode.
    logic w_unused_addr_lsbs;
    assign w_unused_addr_lsbs = ^{s_axi.S_AXI_AWADDR[ADDR_LSB-1:0],
                                  s_axi.S_AXI_ARADDR[ADDR_LSB-1:0]};

    always_comb begin
        w_wmask = '0;
        for (int b = 0; b < STRB_W; b++) begin
            w_wmask[b*8 +: 8] = {8{r_w_strb[b]}};
        end
    end

    always_comb begin
        w_wr_resp = RESP_DECERR;
        if (w_aw_idx < NUM_REGS) begin
            w_wr_resp = RESP_OKAY;
        end else if (w_aw_idx < NUM_REGS + NUM_STATUS) begin
            w_wr_resp = RESP_SLVERR;
        end
`ifdef DISP_REGBANK_IRQ_EN
        else if (w_aw_idx == IRQ_STAT_IDX || w_aw_idx == IRQ_EN_IDX) begin
            w_wr_resp = RESP_OKAY;
        end
`endif
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_aw_held <= 1'b0;
            r_aw_idx  <= '0;
            r_w_held  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= s_axi.S_AXI_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_w_data <= s_axi.S_AXI_WDATA;
                r_w_strb <= s_axi.S_AXI_WSTRB;
            end
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_resp;
            end else if (r_bvalid && s_axi.S_AXI_BREADY) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_ctrl[k] <= '0;
            end
        end else if (w_commit) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (w_aw_idx == k) begin
                    r_ctrl[k] <= (r_ctrl[k] & ~w_wmask) | (r_w_data & w_wmask);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_ctrl_out
        assign ctrl_out[g*DATA_WIDTH +: DATA_WIDTH] = r_ctrl[g];
    end

`ifdef DISP_REGBANK_IRQ_EN
    logic [IRQ_WIDTH-1:0] r_irq_stat;
    logic [IRQ_WIDTH-1:0] r_irq_en;
    logic                 r_irq;
    logic [IRQ_WIDTH-1:0] w_irq_mask;
    logic [IRQ_WIDTH-1:0] w_irq_clr;

    assign w_irq_mask = w_wmask[IRQ_WIDTH-1:0];
    assign w_irq_clr  = (w_commit && w_aw_idx == IRQ_STAT_IDX)
                      ? (r_w_data[IRQ_WIDTH-1:0] & w_irq_mask) : '0;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_irq_stat <= '0;
            r_irq_en   <= '0;
            r_irq      <= 1'b0;
        end else begin
            // OR-ing the sources after the clear makes a same-cycle set win.
            r_irq_stat <= (r_irq_stat & ~w_irq_clr) | irq_src;
            if (w_commit && w_aw_idx == IRQ_EN_IDX) begin
                r_irq_en <= (r_irq_en & ~w_irq_mask) | (r_w_data[IRQ_WIDTH-1:0] & w_irq_mask);
            end
            r_irq <= |(r_irq_stat & r_irq_en);
        end
    end

    assign irq = r_irq;
`else
    logic w_unused_irq_src;
    assign w_unused_irq_src = ^irq_src;
    assign irq = 1'b0;
`endif

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_DECERR;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (w_ar_idx == k) begin
                w_rd_data = r_ctrl[k];
                w_rd_resp = RESP_OKAY;
            end
        end
        for (int k = 0; k < NUM_STATUS; k++) begin
            if (w_ar_idx == NUM_REGS + k) begin
                w_rd_data = status_in[k*DATA_WIDTH +: DATA_WIDTH];
                w_rd_resp = RESP_OKAY;
            end
        end
`ifdef DISP_REGBANK_IRQ_EN
        if (w_ar_idx == IRQ_STAT_IDX) begin
            w_rd_data = DATA_WIDTH'(r_irq_stat);
            w_rd_resp = RESP_OKAY;
        end
        if (w_ar_idx == IRQ_EN_IDX) begin
            w_rd_data = DATA_WIDTH'(r_irq_en);
            w_rd_resp = RESP_OKAY;
        end
`endif
    end

    // Read data is captured from the current register state, so a write
    // committing on the same edge is not yet visible to this read.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
            r_rresp  <= w_rd_resp;
        end else if (r_rvalid && s_axi.S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
        end
    end
endmodule
